seg_scan_decoder: RTL

- Decoder at the receive end of the multiplexed seven-segment display bus. It is the inverse of the team's binary-to-7seg encoder.
- Samples the scanned segment pattern and the one-hot digit select, waits for the pattern to be stable, then decodes it back to a 4-bit hex value per digit.
- Used by self-check logic on the pedestrian-light board and as a bus monitor in the system bench.

---
 rtl/seg_scan_decoder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_decoder
// Purpose  : Receive-side decoder for a multiplexed seven-segment bus.
//            Samples the segment pattern and one-hot digit select, waits for
//            STABLE_CYCLES identical samples, then decodes the pattern back
//            to a 4-bit hex value for the selected digit.
// Revision : 1.0  initial release
// ============================================================================
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] digit_val,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    update_pulse,
  output logic                    sel_err
);

  localparam logic [3:0] C_STABLE = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [3:0]                run_cnt_q, run_cnt_d;
  logic [6:0]                s_seg_q, s_seg_d;
  logic [NUM_DIGITS-1:0]     s_sel_q, s_sel_d;
  logic [4*NUM_DIGITS-1:0]   digit_val_q, digit_val_d;
  logic [NUM_DIGITS-1:0]     digit_valid_q, digit_valid_d;
  logic [NUM_DIGITS-1:0]     digit_err_q, digit_err_d;
  logic                      update_pulse_q, update_pulse_d;
  logic                      sel_err_q, sel_err_d;

  logic                      w_same;
  logic                      w_new_onehot;
  logic                      w_capture;
  logic                      w_legal;
  logic [3:0]                w_value;

  // Population count of a select vector (at most 8 bits wide).
  function automatic logic [3:0] popcnt(input logic [NUM_DIGITS-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      c = c + 4'(v[i]);
    end
    return c;
  endfunction

  // Inverse of the hex-to-7seg table; sets legal=0 for any other pattern.
  function automatic logic [4:0] decode7(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b0111111: r = {1'b1, 4'h0};
      7'b0000110: r = {1'b1, 4'h1};
      7'b1011011: r = {1'b1, 4'h2};
      7'b1001111: r = {1'b1, 4'h3};
      7'b1100110: r = {1'b1, 4'h4};
      7'b1101101: r = {1'b1, 4'h5};
      7'b1111101: r = {1'b1, 4'h6};
      7'b0000111: r = {1'b1, 4'h7};
      7'b1111111: r = {1'b1, 4'h8};
      7'b1101111: r = {1'b1, 4'h9};
      7'b1110111: r = {1'b1, 4'hA};
      7'b1111100: r = {1'b1, 4'hB};
      7'b0111001: r = {1'b1, 4'hC};
      7'b1011110: r = {1'b1, 4'hD};
      7'b1111001: r = {1'b1, 4'hE};
      7'b1110001: r = {1'b1, 4'hF};
      default:    r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  // Next-state logic: sampling, stable-run counting, FSM and capture.
  always_comb begin
    state_d        = state_q;
    run_cnt_d      = run_cnt_q;
    s_seg_d        = seg_in;
    s_sel_d        = dig_sel;
    digit_val_d    = digit_val_q;
    digit_valid_d  = digit_valid_q;
    digit_err_d    = digit_err_q;
    update_pulse_d = 1'b0;
    sel_err_d      = (popcnt(dig_sel) > 4'd1);

    w_same       = ({seg_in, dig_sel} == {s_seg_q, s_sel_q});
    w_new_onehot = (popcnt(dig_sel) == 4'd1);
    {w_legal, w_value} = decode7(s_seg_q);

    // The held sample has already been seen STABLE_CYCLES times.
    w_capture = (state_q == SETTLE) && (run_cnt_q == C_STABLE);

    if (w_same) begin
      if (run_cnt_q != C_STABLE) begin
        run_cnt_d = run_cnt_q + 4'd1;
      end
    end else begin
      run_cnt_d = 4'd1;
    end

    case (state_q)
      IDLE: begin
        if (w_new_onehot) state_d = SETTLE;
      end
      SETTLE: begin
        if (!w_new_onehot)  state_d = IDLE;
        else if (w_capture) state_d = w_same ? HELD : SETTLE;
        else                state_d = SETTLE;
      end
      HELD: begin
        if (!w_same) state_d = w_new_onehot ? SETTLE : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Only the digit named by the captured select is written.
    if (w_capture) begin
      update_pulse_d = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (s_sel_q[i]) begin
          if (w_legal) begin
            digit_val_d[4*i +: 4] = w_value;
            digit_valid_d[i]      = 1'b1;
            digit_err_d[i]        = 1'b0;
          end else begin
            digit_valid_d[i]      = 1'b0;
            digit_err_d[i]        = 1'b1;
          end
        end
      end
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      run_cnt_q      <= 4'd0;
      s_seg_q        <= 7'd0;
      s_sel_q        <= '0;
      digit_val_q    <= '0;
      digit_valid_q  <= '0;
      digit_err_q    <= '0;
      update_pulse_q <= 1'b0;
      sel_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      run_cnt_q      <= run_cnt_d;
      s_seg_q        <= s_seg_d;
      s_sel_q        <= s_sel_d;
      digit_val_q    <= digit_val_d;
      digit_valid_q  <= digit_valid_d;
      digit_err_q    <= digit_err_d;
      update_pulse_q <= update_pulse_d;
      sel_err_q      <= sel_err_d;
    end
  end

  assign digit_val    = digit_val_q;
  assign digit_valid  = digit_valid_q;
  assign digit_err    = digit_err_q;
  assign update_pulse = update_pulse_q;
  assign sel_err      = sel_err_q;

endmodule
`default_nettype wire
